// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback against a stalling memory.
module multicycle_ctrl #(
  parameter int unsigned STALL_LIMIT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [1:0]       imm_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic             adr_src,
  output logic             mem_req,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_HALT
  } state_t;

  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_B  = 7'b1100011;

  localparam int SW =
    (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT + 1) : 1;
  localparam int unsigned LIM_M1I =
    (STALL_LIMIT == 0) ? 0 : STALL_LIMIT - 1;
  localparam logic [SW-1:0] LIM_M1 = SW'(LIM_M1I);
  localparam bit LIM_EN = (STALL_LIMIT != 0);

  state_t        state;
  state_t        nxt;
  logic [SW-1:0] stall_q;
  logic [1:0]    fault_q;
  logic [CNT_W-1:0] ret_q;

  logic mem_st;
  logic timeout;
  logic ill;
  logic retire;
  logic is_ld;
  logic is_st;
  logic is_r;
  logic is_i;
  logic is_br;

  assign is_ld = (op == OP_LD);
  assign is_st = (op == OP_ST);
  assign is_r  = (op == OP_R);
  assign is_i  = (op == OP_I);
  assign is_br = (op == OP_B) && (funct3[2:1] == 2'b00);

  assign mem_st = (state == S_FETCH)
               || (state == S_MEMREAD)
               || (state == S_MEMWRITE);
  assign mem_req = mem_st;

  // The limit cycle still completes if mem_ready arrives in it.
  assign timeout = LIM_EN && mem_st && !mem_ready
                && (stall_q == LIM_M1);

  always_comb begin
    nxt        = state;
    imm_src    = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    ill        = 1'b0;
    retire     = 1'b0;
    unique case (state)
      S_RESET: nxt = S_FETCH;
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt      = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 2'b10;
        unique case (1'b1)
          is_ld, is_st: nxt = S_MEMADR;
          is_r:         nxt = S_EXEC_R;
          is_i:         nxt = S_EXEC_I;
          is_br:        nxt = S_BRANCH;
          default: begin
            nxt = S_HALT;
            ill = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = is_st ? 2'b01 : 2'b00;
        nxt       = is_st ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) nxt = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        nxt        = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          retire = 1'b1;
          nxt    = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        nxt       = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        nxt       = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        nxt       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = zero ^ funct3[0];
        retire    = 1'b1;
        nxt       = S_FETCH;
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_HALT;
    endcase
    if (timeout) nxt = S_HALT;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_RESET;
      stall_q <= '0;
      fault_q <= 2'b00;
      ret_q   <= '0;
    end else begin
      state <= nxt;
      if (mem_st && !mem_ready)
        stall_q <= stall_q + SW'(1);
      else
        stall_q <= '0;
      if (fault_q == 2'b00) begin
        if (ill)
          fault_q <= 2'b01;
        else if (timeout)
          fault_q <= 2'b10;
      end
      if (retire) ret_q <= ret_q + CNT_W'(1);
    end
  end

  assign fault   = fault_q;
  assign retired = ret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl.
// Built with STALL_LIMIT=4, CNT_W=4 so timeout and wrap are reachable.
module tb_multicycle_ctrl;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic [1:0] imm_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] result_src;
  logic       adr_src;
  logic       mem_req;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] fault;
  logic [3:0] retired;
  logic [15:0] ctl;

  int ncmp;
  int nfail;

  multicycle_ctrl #(
    .STALL_LIMIT(4),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .op(op),
    .funct3(funct3),
    .zero(zero),
    .mem_ready(mem_ready),
    .imm_src(imm_src),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .alu_op(alu_op),
    .result_src(result_src),
    .adr_src(adr_src),
    .mem_req(mem_req),
    .mem_write(mem_write),
    .ir_write(ir_write),
    .pc_write(pc_write),
    .reg_write(reg_write),
    .fault(fault),
    .retired(retired)
  );

  // {imm,a,b,aluop,res, adr,req,wr,irw,pcw,rw}
  assign ctl = {imm_src, alu_src_a, alu_src_b,
                alu_op, result_src, adr_src,
                mem_req, mem_write, ir_write,
                pc_write, reg_write};

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  localparam logic [15:0] C_ZERO = 16'h0000;
  localparam logic [15:0] C_FR =
    {2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 6'b010110};
  localparam logic [15:0] C_FW =
    {2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 6'b010000};
  localparam logic [15:0] C_DEC =
    {2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 6'b000000};
  localparam logic [15:0] C_MAL =
    {2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 6'b000000};
  localparam logic [15:0] C_MAS =
    {2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 6'b000000};
  localparam logic [15:0] C_MRD =
    {2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 6'b110000};
  localparam logic [15:0] C_MWB =
    {2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 6'b000001};
  localparam logic [15:0] C_MWR =
    {2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 6'b111000};
  localparam logic [15:0] C_EXR =
    {2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 6'b000000};
  localparam logic [15:0] C_EXI =
    {2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 6'b000000};
  localparam logic [15:0] C_AWB =
    {2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 6'b000001};
  localparam logic [15:0] C_BRT =
    {2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 6'b000010};
  localparam logic [15:0] C_BRN =
    {2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 6'b000000};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    #1;
    ncmp++;
    if (ctl !== C_ZERO) begin
      nfail++;
      $display("FAIL reset_ctl got %h exp %h", ctl, C_ZERO);
    end
    ncmp++;
    if (fault !== 2'b00) begin
      nfail++;
      $display("FAIL reset_fault got %b exp 00", fault);
    end
    ncmp++;
    if (retired !== 4'd0) begin
      nfail++;
      $display("FAIL reset_retired got %0d exp 0", retired);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_zero_wait;
    logic [6:0]  ops [17] = '{7'd0,
      OP_I, OP_I, OP_I, OP_I,
      OP_LW, OP_LW, OP_LW, OP_LW, OP_LW,
      OP_SW, OP_SW, OP_SW, OP_SW,
      OP_B, OP_B, OP_B};
    logic [2:0]  f3s [17] = '{3'd0,
      3'd0, 3'd0, 3'd0, 3'd0,
      3'd2, 3'd2, 3'd2, 3'd2, 3'd2,
      3'd2, 3'd2, 3'd2, 3'd2,
      3'd0, 3'd0, 3'd0};
    logic [15:0] ex [17] = '{C_ZERO,
      C_FR, C_DEC, C_EXI, C_AWB,
      C_FR, C_DEC, C_MAL, C_MRD, C_MWB,
      C_FR, C_DEC, C_MAS, C_MWR,
      C_FR, C_DEC, C_BRN};
    for (int i = 0; i < 17; i++) begin
      op = ops[i];
      funct3 = f3s[i];
      zero = 1'b0;
      mem_ready = 1'b1;
      #1;
      ncmp++;
      if (ctl !== ex[i]) begin
        nfail++;
        $display("FAIL zero_wait cyc %0d got %h exp %h",
                 i, ctl, ex[i]);
      end
      tick();
    end
    #1;
    ncmp++;
    if (retired !== 4'd4) begin
      nfail++;
      $display("FAIL zero_wait_retired got %0d exp 4", retired);
    end
  endtask

  task automatic test_branch;
    logic [2:0]  f3s [9] = '{3'd0, 3'd0, 3'd0,
      3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
    logic        zs  [9] = '{1'b1, 1'b1, 1'b1,
      1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] ex  [9] = '{C_FR, C_DEC, C_BRT,
      C_FR, C_DEC, C_BRN, C_FR, C_DEC, C_BRT};
    for (int i = 0; i < 9; i++) begin
      op = OP_B;
      funct3 = f3s[i];
      zero = zs[i];
      mem_ready = 1'b1;
      #1;
      ncmp++;
      if (ctl !== ex[i]) begin
        nfail++;
        $display("FAIL branch cyc %0d got %h exp %h",
                 i, ctl, ex[i]);
      end
      tick();
    end
    #1;
    ncmp++;
    if (retired !== 4'd7) begin
      nfail++;
      $display("FAIL branch_retired got %0d exp 7", retired);
    end
  endtask

  task automatic test_mem_stall;
    logic        rdy [8] = '{1'b1, 1'b1, 1'b1,
      1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] ex  [8] = '{C_FR, C_DEC, C_MAL,
      C_MRD, C_MRD, C_MRD, C_MRD, C_MWB};
    for (int i = 0; i < 8; i++) begin
      op = OP_LW;
      funct3 = 3'd2;
      zero = 1'b0;
      mem_ready = rdy[i];
      #1;
      ncmp++;
      if (ctl !== ex[i]) begin
        nfail++;
        $display("FAIL mem_stall cyc %0d got %h exp %h",
                 i, ctl, ex[i]);
      end
      tick();
    end
    #1;
    ncmp++;
    if (ctl !== C_FR) begin
      nfail++;
      $display("FAIL mem_stall_back got %h exp %h", ctl, C_FR);
    end
    ncmp++;
    if (retired !== 4'd8 || fault !== 2'b00) begin
      nfail++;
      $display("FAIL mem_stall_ret got %0d/%b exp 8/00",
               retired, fault);
    end
  endtask

  task automatic test_fetch_limit_ok;
    logic        rdy [7] = '{1'b0, 1'b0, 1'b0,
      1'b1, 1'b1, 1'b1, 1'b1};
    logic [15:0] ex  [7] = '{C_FW, C_FW, C_FW,
      C_FR, C_DEC, C_EXI, C_AWB};
    for (int i = 0; i < 7; i++) begin
      op = OP_I;
      funct3 = 3'd0;
      mem_ready = rdy[i];
      #1;
      ncmp++;
      if (ctl !== ex[i]) begin
        nfail++;
        $display("FAIL limit_ok cyc %0d got %h exp %h",
                 i, ctl, ex[i]);
      end
      tick();
    end
    #1;
    ncmp++;
    if (retired !== 4'd9 || fault !== 2'b00) begin
      nfail++;
      $display("FAIL limit_ok_ret got %0d/%b exp 9/00",
               retired, fault);
    end
  endtask

  task automatic test_timeout;
    logic        rdy [6] = '{1'b0, 1'b0, 1'b0,
      1'b0, 1'b1, 1'b1};
    logic [15:0] ex  [6] = '{C_FW, C_FW, C_FW,
      C_FW, C_ZERO, C_ZERO};
    for (int i = 0; i < 6; i++) begin
      op = OP_I;
      mem_ready = rdy[i];
      #1;
      ncmp++;
      if (ctl !== ex[i]) begin
        nfail++;
        $display("FAIL timeout cyc %0d got %h exp %h",
                 i, ctl, ex[i]);
      end
      tick();
    end
    #1;
    ncmp++;
    if (fault !== 2'b10 || retired !== 4'd9) begin
      nfail++;
      $display("FAIL timeout_fault got %b/%0d exp 10/9",
               fault, retired);
    end
    rst_n = 1'b0;
    tick();
    #1;
    ncmp++;
    if (ctl !== C_ZERO || fault !== 2'b00 || retired !== 4'd0) begin
      nfail++;
      $display("FAIL timeout_reset got %h/%b/%0d exp 0000/00/0",
               ctl, fault, retired);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_illegal;
    logic [15:0] ex [4] = '{C_FR, C_DEC, C_ZERO, C_ZERO};
    for (int i = 0; i < 4; i++) begin
      op = OP_BAD;
      funct3 = 3'd0;
      mem_ready = 1'b1;
      #1;
      ncmp++;
      if (ctl !== ex[i]) begin
        nfail++;
        $display("FAIL illegal cyc %0d got %h exp %h",
                 i, ctl, ex[i]);
      end
      tick();
    end
    #1;
    ncmp++;
    if (fault !== 2'b01) begin
      nfail++;
      $display("FAIL illegal_fault got %b exp 01", fault);
    end
    rst_n = 1'b0;
    tick();
    #1;
    ncmp++;
    if (ctl !== C_ZERO || fault !== 2'b00) begin
      nfail++;
      $display("FAIL illegal_reset got %h/%b exp 0000/00",
               ctl, fault);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_midwrite;
    logic        rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] ex  [5] = '{C_FR, C_DEC, C_MAS, C_MWR, C_MWR};
    for (int i = 0; i < 5; i++) begin
      op = OP_SW;
      funct3 = 3'd2;
      mem_ready = rdy[i];
      #1;
      ncmp++;
      if (ctl !== ex[i]) begin
        nfail++;
        $display("FAIL midwrite cyc %0d got %h exp %h",
                 i, ctl, ex[i]);
      end
      tick();
    end
    rst_n = 1'b0;
    mem_ready = 1'b1;
    tick();
    #1;
    ncmp++;
    if (mem_write !== 1'b0 || ctl !== C_ZERO) begin
      nfail++;
      $display("FAIL midwrite_abort got %b/%h exp 0/0000",
               mem_write, ctl);
    end
    ncmp++;
    if (retired !== 4'd0) begin
      nfail++;
      $display("FAIL midwrite_retired got %0d exp 0", retired);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_wrap;
    logic [15:0] ex;
    logic [3:0]  exp_ret;
    for (int n = 0; n < 16; n++) begin
      for (int c = 0; c < 4; c++) begin
        op = n[0] ? OP_I : OP_R;
        funct3 = 3'd0;
        mem_ready = 1'b1;
        case (c)
          0: ex = C_FR;
          1: ex = C_DEC;
          2: ex = n[0] ? C_EXI : C_EXR;
          default: ex = C_AWB;
        endcase
        #1;
        ncmp++;
        if (ctl !== ex) begin
          nfail++;
          $display("FAIL wrap n %0d cyc %0d got %h exp %h",
                   n, c, ctl, ex);
        end
        tick();
      end
      exp_ret = 4'((n + 1) % 16);
      ncmp++;
      if (retired !== exp_ret) begin
        nfail++;
        $display("FAIL wrap_retired n %0d got %0d exp %0d",
                 n, retired, exp_ret);
      end
    end
  endtask

  initial begin
    ncmp = 0;
    nfail = 0;
    rst_n = 1'b0;
    op = 7'd0;
    funct3 = 3'd0;
    zero = 1'b0;
    mem_ready = 1'b0;
    test_reset();
    test_zero_wait();
    test_branch();
    test_mem_stall();
    test_fetch_limit_ok();
    test_timeout();
    test_illegal();
    test_reset_midwrite();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
